// File: rtl/gtfraw_pmtick_stats_reader_if.sv
// ---------------------------------------------------------------------------
// gtfraw_pmtick_stats_reader_if
//   Word stream from the pm_tick statistics reader to the host/stats bridge.
//   rd_data   32-bit counter word
//   rd_index  word index within the snapshot (LS word of stat 0 is index 0)
//   rd_last   marks the final word of a snapshot
//   rd_valid  word valid
//   rd_ready  consumer accept
//   master = reader side, slave = consumer side.
// ---------------------------------------------------------------------------
interface gtfraw_pmtick_stats_reader_if #(
  parameter int IDXW = 4
) ();
  logic [31:0]     rd_data;
  logic [IDXW-1:0] rd_index;
  logic            rd_last;
  logic            rd_valid;
  logic            rd_ready;

  modport master (
    output rd_data,
    output rd_index,
    output rd_last,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_index,
    input  rd_last,
    input  rd_valid,
    output rd_ready
  );
endinterface

// File: rtl/gtfraw_pmtick_stats_reader.sv
// ---------------------------------------------------------------------------
// gtfraw_pmtick_stats_reader
//   Master side of the pm_tick statistics interface. A snapshot is triggered
//   by a software request or by the periodic timer. The reader strobes
//   pm_tick to every stats register, waits SETTLE_CYC cycles for the
//   snapshots to reach statsout, raises hold_output to freeze them, then
//   streams every counter as 32-bit words (LS word of stat 0 first).
//
// Ports
//   clk, resetn    clock; asynchronous active-low reset (released synchronously)
//   tick_period    periodic trigger interval in cycles, 0 disables the timer
//   tick_req       single-cycle software snapshot request
//   stats_in       statsout of all registers, stat i at [i*STATWIDTH +: STATWIDTH]
//   pm_tick        one-cycle snapshot strobe
//   hold_output    freeze strobe, high from HOLD_ON through the final handshake
//   snap_busy      snapshot in progress
//   snap_count     completed snapshots (wraps)
//   tick_dropped   triggers ignored while busy (saturates)
//   rd_if          word stream (master modport)
//
// STATWIDTH must be a multiple of 32 and SETTLE_CYC must be at least 4.
// ---------------------------------------------------------------------------
module gtfraw_pmtick_stats_reader #(
  parameter int NUM_STATS  = 8,
  parameter int STATWIDTH  = 64,
  parameter int SETTLE_CYC = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [31:0]                    tick_period,
  input  logic                           tick_req,
  input  logic [NUM_STATS*STATWIDTH-1:0] stats_in,
  output logic                           pm_tick,
  output logic                           hold_output,
  output logic                           snap_busy,
  output logic [15:0]                    snap_count,
  output logic [15:0]                    tick_dropped,
  gtfraw_pmtick_stats_reader_if.master   rd_if
);

  localparam int WPS       = STATWIDTH / 32;
  localparam int NUM_WORDS = NUM_STATS * WPS;
  localparam int IDXW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int SCW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TICK,
    S_SETTLE,
    S_HOLD_ON,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  // -------------------------------------------------------------------------
  // Reset: assertion is asynchronous, release is synchronised to clk so that
  // every flop leaves reset on the same edge.
  // -------------------------------------------------------------------------
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_reg[1];

  // -------------------------------------------------------------------------
  // Flatten stats_in into a word array in stream order. Because STATWIDTH is
  // a multiple of 32, word w of the snapshot sits at bit w*32 of stats_in.
  // -------------------------------------------------------------------------
  logic [31:0] word_arr [NUM_WORDS];

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
    assign word_arr[gi] = stats_in[gi*32 +: 32];
  end

  // -------------------------------------------------------------------------
  // Period timer. The compare uses the live tick_period so a new value is
  // honoured on the very next compare; >= catches a period shortened below
  // the current count.
  // -------------------------------------------------------------------------
  logic [31:0] timer_reg;
  logic        timer_fire;
  logic        trig;

  assign timer_fire = (tick_period != 32'd0) && (timer_reg >= (tick_period - 32'd1));
  assign trig       = tick_req | timer_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= 32'd0;
    end else if ((tick_period == 32'd0) || timer_fire) begin
      timer_reg <= 32'd0;
    end else begin
      timer_reg <= timer_reg + 32'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Snapshot FSM
  // -------------------------------------------------------------------------
  state_t          state_reg, state_next;
  logic [SCW-1:0]  settle_reg, settle_next;
  logic [IDXW-1:0] ptr_reg, ptr_next;
  logic [15:0]     snap_count_reg, snap_count_next;
  logic [15:0]     tick_dropped_reg, tick_dropped_next;
  logic            load_word;

  logic            pm_tick_reg;
  logic            hold_output_reg;
  logic            rd_valid_reg;
  logic [31:0]     rd_data_reg;
  logic [IDXW-1:0] rd_index_reg;
  logic            rd_last_reg;

  always_comb begin
    state_next        = state_reg;
    settle_next       = settle_reg;
    ptr_next          = ptr_reg;
    snap_count_next   = snap_count_reg;
    tick_dropped_next = tick_dropped_reg;
    load_word         = 1'b0;

    // Any trigger outside IDLE is lost; the one that starts a snapshot is not.
    if (trig && (state_reg != S_IDLE) && (tick_dropped_reg != 16'hFFFF)) begin
      tick_dropped_next = tick_dropped_reg + 16'd1;
    end

    case (state_reg)
      S_IDLE: begin
        if (trig) begin
          state_next = S_TICK;
        end
      end
      S_TICK: begin
        state_next  = S_SETTLE;
        settle_next = SCW'(SETTLE_CYC - 1);
      end
      S_SETTLE: begin
        if (settle_reg == '0) begin
          state_next = S_HOLD_ON;
        end else begin
          settle_next = settle_reg - 1'b1;
        end
      end
      S_HOLD_ON: begin
        state_next = S_LOAD;
        ptr_next   = '0;
      end
      S_LOAD: begin
        state_next = S_SEND;
        load_word  = 1'b1;
      end
      S_SEND: begin
        // rd_valid is always high in SEND, so rd_ready alone completes the beat.
        if (rd_if.rd_ready) begin
          if (rd_last_reg) begin
            state_next = S_DONE;
          end else begin
            ptr_next   = ptr_reg + 1'b1;
            state_next = S_LOAD;
          end
        end
      end
      S_DONE: begin
        snap_count_next = snap_count_reg + 16'd1;
        state_next      = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Strobes are registered and decoded from the next state so that they line
  // up with the state they belong to without a combinational output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      settle_reg       <= '0;
      ptr_reg          <= '0;
      snap_count_reg   <= 16'd0;
      tick_dropped_reg <= 16'd0;
      pm_tick_reg      <= 1'b0;
      hold_output_reg  <= 1'b0;
      rd_valid_reg     <= 1'b0;
      rd_data_reg      <= 32'd0;
      rd_index_reg     <= '0;
      rd_last_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      settle_reg       <= settle_next;
      ptr_reg          <= ptr_next;
      snap_count_reg   <= snap_count_next;
      tick_dropped_reg <= tick_dropped_next;
      pm_tick_reg      <= (state_next == S_TICK);
      hold_output_reg  <= (state_next == S_HOLD_ON) ||
                          (state_next == S_LOAD)    ||
                          (state_next == S_SEND);
      rd_valid_reg     <= (state_next == S_SEND);
      // Word fields only change in LOAD, which keeps them stable during a stall.
      if (load_word) begin
        rd_data_reg  <= word_arr[ptr_reg];
        rd_index_reg <= ptr_reg;
        rd_last_reg  <= (ptr_reg == IDXW'(NUM_WORDS - 1));
      end
    end
  end

  assign pm_tick        = pm_tick_reg;
  assign hold_output    = hold_output_reg;
  assign snap_busy      = (state_reg != S_IDLE);
  assign snap_count     = snap_count_reg;
  assign tick_dropped   = tick_dropped_reg;
  assign rd_if.rd_data  = rd_data_reg;
  assign rd_if.rd_index = rd_index_reg;
  assign rd_if.rd_last  = rd_last_reg;
  assign rd_if.rd_valid = rd_valid_reg;

endmodule
